alu_requester: RTL and testbench
================================

Name: alu_requester

Overview:
- Initiator-side front end for the ALU controller.
- Accepts operand pairs from an upstream valid/ready stream and drives the ALU controller's start/A/B inputs.
- Waits for the controller's done, captures its C result, and returns the result on a downstream valid/ready stream.
- Includes a bounded timeout so a hung controller cannot stall the pipeline.

Parameters:
- DATA_W, 8, width of operands and result (matches ALU controller A/B/C).
- TIMEOUT_CYCLES, 255, maximum WAIT cycles without done before an error is flagged; legal range 1..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  DATA_W  operand A.
- in_b  input  DATA_W  operand B.
- start  output  1  one-cycle request pulse to the ALU controller.
- A  output  DATA_W  operand A to the ALU controller.
- B  output  DATA_W  operand B to the ALU controller.
- C  input  DATA_W  result from the ALU controller.
- done  input  1  completion strobe from the ALU controller.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_c  output  DATA_W  captured result.
- out_err  output  1  result is a timeout error, not a valid C.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE.
  - start=0, A=0, B=0, out_valid=0, out_c=0, out_err=0, timer=0.
  - in_ready and busy are decoded from state, so after any reset edge in_ready=1 and busy=0.
  - Reset mid-operation abandons the transaction with no result emitted; start is low from the reset edge.
- States: IDLE, ISSUE, WAIT, RESULT. All outputs registered except in_ready and busy.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register A<=in_a, B<=in_b, then go to ISSUE.
- ISSUE:
  - start=1 for exactly this one cycle; timer cleared; next state WAIT.
  - done is ignored in ISSUE.
- WAIT:
  - start=0; A/B held stable.
  - If done: out_c<=C, out_err<=0, out_valid<=1, go to RESULT.
  - Else if timer==TIMEOUT_CYCLES-1: out_c<=0, out_err<=1, out_valid<=1, go to RESULT.
  - Else timer+1.
  - done and timeout in the same cycle: done wins.
- RESULT:
  - out_valid=1; out_c and out_err held stable.
  - On out_ready: out_valid<=0, go to IDLE.
  - A and B are retained, not cleared.
- Latency:
  - Accept at edge N, start high in cycle N+1.
  - Earliest done sample in cycle N+2, out_valid high in cycle N+3.
  - Earliest re-accept is one cycle after the out handshake (no overlap; one transaction in flight).
- done while in IDLE or RESULT is ignored (spurious strobe, no state change).
- Timer width: clog2(TIMEOUT_CYCLES+1); never wraps, because it is cleared in ISSUE and bounded in WAIT.
- An out_ready held high before RESULT has no effect. The handshake completes only at an edge with out_valid==1.

Optional Feature:
- Macro: ALU_REQ_STATS_EN.
- With the macro defined, extra output ports are present:
  - req_count [15:0]: increments on each out handshake with out_err==0.
  - err_count [7:0]: increments on each out handshake with out_err==1.
  - Both counters saturate at all-ones and are cleared by reset.
- Without the macro, these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared definitions file alu_req_defs.vh holds:
  - State encodings: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESULT=2'd3.
  - DATA_W default value.
- One sub-module, alu_req_timer: clear, enable, terminal-count flag, parameterised by TIMEOUT_CYCLES. It is instantiated once.

Test Plan:
- Basic op: reset low 2 cycles then high; in_a=8'h12, in_b=8'h34, in_valid=1. Expected:
  - start pulses 1 cycle with A=12, B=34.
  - Model drives done with C=8'h46 two cycles later.
  - out_valid=1, out_c=46, out_err=0; clears after out_ready.
- Timeout: TIMEOUT_CYCLES=4, done never asserted -> after exactly 4 WAIT cycles out_valid=1, out_err=1, out_c=0; busy stays 1 until out_ready.
- Backpressure: out_ready=0 for 10 cycles after a result -> out_valid and out_c stable; in_ready=0 throughout; a new in_valid is not accepted until the cycle after out_ready.
- Simultaneous done and timeout: done asserted on the last WAIT cycle (timer==TIMEOUT_CYCLES-1) -> out_err=0 and out_c=C.
- Reset mid-WAIT: reset low during WAIT -> next cycle start=0, out_valid=0, in_ready=1. A late done after reset produces no result.
- ALU_REQ_STATS_EN: 3 good transactions and 1 timeout -> req_count=3, err_count=1. Forcing 300 timeouts -> err_count=8'hFF (saturated).

Source files
------------

// File: rtl/alu_requester_pkg.sv
// Shared definitions for the ALU requester: FSM state encoding and default data width.
package alu_requester_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

endpackage

// File: rtl/alu_req_timer.sv
// WAIT-phase cycle counter for the ALU requester; flags the last allowed cycle before timeout.
module alu_req_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TW'(1);
    end
  end

  assign tc = (count == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_requester.sv
// Initiator front end for the ALU controller: one operand pair in flight, bounded wait for done.
// Define ALU_REQ_STATS_EN to add saturating good/error result counters.
module alu_requester
  import alu_requester_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              start,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] C,
  input  logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_c,
  output logic              out_err,
  output logic              busy
`ifdef ALU_REQ_STATS_EN
  ,
  output logic [15:0]       req_count,
  output logic [7:0]        err_count
`endif
);

  state_t state_q, state_d;
  logic              start_d;
  logic [DATA_W-1:0] a_d, b_d, c_d;
  logic              valid_d, err_d;
  logic              timer_clear, timer_en, timer_tc;

  alu_req_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .tc     (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      start     <= 1'b0;
      A         <= '0;
      B         <= '0;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      start     <= start_d;
      A         <= a_d;
      B         <= b_d;
      out_valid <= valid_d;
      out_c     <= c_d;
      out_err   <= err_d;
    end
  end

  // start is registered, so it is raised on the accept edge and lives exactly for the ISSUE cycle
  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    a_d         = A;
    b_d         = B;
    c_d         = out_c;
    valid_d     = out_valid;
    err_d       = out_err;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    in_ready    = (state_q == IDLE);
    busy        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_clear = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (done) begin
          c_d     = C;
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = RESULT;
        end else if (timer_tc) begin
          c_d     = '0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          state_d = RESULT;
        end else begin
          timer_en = 1'b1;
        end
      end
      RESULT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_REQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_count <= '0;
      err_count <= '0;
    end else if (out_valid && out_ready) begin
      if (!out_err && req_count != '1) req_count <= req_count + 16'd1;
      if (out_err && err_count != '1)  err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_requester.sv
// Self-checking bench for alu_requester: acts as the ALU controller (C = A + B) and checks
// results against an outcome model derived from done timing and the timeout bound.
module tb_alu_requester;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       start;
  logic [7:0] A, B;
  logic [7:0] C = '0;
  logic       done = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_c;
  logic       out_err;
  logic       busy;
`ifdef ALU_REQ_STATS_EN
  logic [15:0] req_count;
  logic [7:0]  err_count;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int goods  = 0;
  int errs   = 0;

  alu_requester #(.DATA_W(8), .TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .start     (start),
    .A         (A),
    .B         (B),
    .C         (C),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_err   (out_err),
    .busy      (busy)
`ifdef ALU_REQ_STATS_EN
    ,
    .req_count (req_count),
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction. dsel = WAIT cycle (1-based) in which done is driven, 0 = never.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int dsel,
                               input int bp, input bit early, input bit spur);
    logic [7:0] expC;
    bit         expErr;
    int         resultAt;
    expErr   = !(dsel >= 1 && dsel <= T);
    expC     = expErr ? 8'h00 : 8'(a + b);
    resultAt = expErr ? T : dsel;

    checkOutput("idle_in_ready", 32'(in_ready), 1);
    checkOutput("idle_busy", 32'(busy), 0);
    in_valid = 1'b1; in_a = a; in_b = b; out_ready = early;
    @(negedge clk);
    in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
    checkOutput("issue_start", 32'(start), 1);
    checkOutput("issue_A", 32'(A), 32'(a));
    checkOutput("issue_B", 32'(B), 32'(b));
    checkOutput("issue_in_ready", 32'(in_ready), 0);
    checkOutput("issue_busy", 32'(busy), 1);
    if (spur) begin done = 1'b1; C = 8'hEE; end
    @(negedge clk);
    done = 1'b0;
    checkOutput("wait_start_low", 32'(start), 0);
    for (int w = 1; w <= resultAt; w++) begin
      if (w == dsel) begin done = 1'b1; C = 8'(a + b); end
      else C = 8'($urandom);
      @(negedge clk);
      done = 1'b0;
      if (w < resultAt) begin
        checkOutput("wait_no_valid", 32'(out_valid), 0);
        checkOutput("wait_A_hold", 32'(A), 32'(a));
        checkOutput("wait_busy", 32'(busy), 1);
      end
    end
    for (int k = 0; k <= bp; k++) begin
      checkOutput("result_valid", 32'(out_valid), 1);
      checkOutput("result_c", 32'(out_c), 32'(expC));
      checkOutput("result_err", 32'(out_err), 32'(expErr));
      checkOutput("result_in_ready", 32'(in_ready), 0);
      checkOutput("result_busy", 32'(busy), 1);
      if (k == bp) begin
        out_ready = 1'b1; done = 1'b0;
      end else begin
        out_ready = 1'b0; in_valid = 1'b1; in_a = 8'($urandom);
        done = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    checkOutput("post_valid_low", 32'(out_valid), 0);
    checkOutput("post_in_ready", 32'(in_ready), 1);
    checkOutput("post_busy", 32'(busy), 0);
    checkOutput("post_start", 32'(start), 0);
    in_valid = 1'b0; out_ready = 1'b0; done = 1'b0;
    if (expErr) errs++; else goods++;
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_start", 32'(start), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_c", 32'(out_c), 0);
    checkOutput("rst_out_err", 32'(out_err), 0);
    checkOutput("rst_A", 32'(A), 0);
    checkOutput("rst_B", 32'(B), 0);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(8'h12, 8'h34, 2, 0, 1'b0, 1'b0);
    applyStimulus(8'hA5, 8'h5A, 1, 0, 1'b0, 1'b0);
    applyStimulus(8'h01, 8'h02, 0, 2, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'h02, T, 10, 1'b0, 1'b1);
    applyStimulus(8'h10, 8'h20, T + 1, 0, 1'b1, 1'b0);

    for (int n = 0; n < 25; n++) begin
      applyStimulus(8'($urandom), 8'($urandom), int'($urandom_range(0, T + 2)),
                    int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end

`ifdef ALU_REQ_STATS_EN
    checkOutput("stats_req", 32'(req_count), 32'((goods > 65535) ? 65535 : goods));
    checkOutput("stats_err", 32'(err_count), 32'((errs > 255) ? 255 : errs));
`endif

    in_valid = 1'b1; in_a = 8'h33; in_b = 8'h44;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_start", 32'(start), 0);
    checkOutput("midrst_valid", 32'(out_valid), 0);
    checkOutput("midrst_in_ready", 32'(in_ready), 1);
    checkOutput("midrst_busy", 32'(busy), 0);
    goods = 0; errs = 0;
    reset = 1'b1; done = 1'b1; C = 8'h55;
    @(negedge clk);
    done = 1'b0;
    checkOutput("late_done_valid", 32'(out_valid), 0);
    checkOutput("late_done_busy", 32'(busy), 0);
    @(negedge clk);
    checkOutput("late_done_valid2", 32'(out_valid), 0);

    applyStimulus(8'h03, 8'h04, 1, 0, 1'b0, 1'b0);
    applyStimulus(8'h05, 8'h06, 3, 1, 1'b0, 1'b0);
    applyStimulus(8'h07, 8'h08, 0, 0, 1'b0, 1'b0);
    applyStimulus(8'h09, 8'h0A, 2, 0, 1'b1, 1'b0);

`ifdef ALU_REQ_STATS_EN
    checkOutput("stats_req_3", 32'(req_count), 3);
    checkOutput("stats_err_1", 32'(err_count), 1);
    for (int n = 0; n < 300; n++) applyStimulus(8'($urandom), 8'($urandom), 0, 0, 1'b1, 1'b0);
    checkOutput("stats_err_sat", 32'(err_count), 32'hFF);
    checkOutput("stats_req_hold", 32'(req_count), 3);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
